// File: rtl/vpg_mode_pkg.sv
// Shared types and constants for the video pattern generator mode controller:
// timing row layout, the CEA mode table and the controller state encoding.
package vpg_mode_pkg;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_act_start;
        logic [11:0] h_act_end;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_act_start;
        logic [11:0] v_act_end;
        logic [1:0]  pclk;
    } timing_t;

    localparam int MAX_MODES = 4;

    // Active window starts after sync + back porch; end is exclusive.
    localparam timing_t MODE_TABLE [MAX_MODES] = '{
        '{12'd800,  12'd96,  12'd144, 12'd784,  12'd525,  12'd2, 12'd35, 12'd515,  2'd0},
        '{12'd1056, 12'd128, 12'd216, 12'd1016, 12'd628,  12'd4, 12'd27, 12'd627,  2'd1},
        '{12'd1650, 12'd40,  12'd260, 12'd1540, 12'd750,  12'd5, 12'd25, 12'd745,  2'd2},
        '{12'd2200, 12'd44,  12'd192, 12'd2112, 12'd1125, 12'd5, 12'd41, 12'd1121, 2'd3}
    };

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_FS = 3'd1,
        ST_BLANK   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

    function automatic logic [2:0] pat_reduce(input logic [2:0] v, input int n);
        return 3'(32'(v) % 32'(n));
    endfunction

    function automatic logic [2:0] pat_step(input logic [2:0] v, input int n);
        return 3'((32'(v) + 32'd1) % 32'(n));
    endfunction

endpackage

// File: rtl/vpg_frame_detect.sv
// Frame boundary detector: synchronises vsync and emits a one-cycle frame_start
// pulse two cycles after the active-going input edge.
module vpg_frame_detect #(
    parameter bit VS_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic vga_vs,
    output logic frame_start
);

    localparam logic VS_IDLE = VS_ACTIVE_LOW;

    logic vs_sync_r;
    logic vs_edge_r;
    logic frame_start_r;

    // Synchroniser, edge history and registered pulse; idle level out of reset avoids a false edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_sync_r     <= VS_IDLE;
            vs_edge_r     <= VS_IDLE;
            frame_start_r <= 1'b0;
        end else begin
            vs_sync_r     <= vga_vs;
            vs_edge_r     <= vs_sync_r;
            frame_start_r <= (vs_sync_r ^ VS_IDLE) & ~(vs_edge_r ^ VS_IDLE);
        end
    end

    assign frame_start = frame_start_r;

endmodule

// File: rtl/vpg_mode_ctrl.sv
// Run-time mode and test-pattern controller for the video pattern generator.
// Mode changes are applied on frame boundaries behind a 4-phase req/ack handshake.
module vpg_mode_ctrl
    import vpg_mode_pkg::*;
#(
    parameter int NUM_MODES         = 4,
    parameter int NUM_PATTERNS      = 8,
    parameter int BLANK_FRAMES      = 2,
    parameter int FRAME_TIMEOUT     = 2000000,
    parameter int AUTO_FRAMES       = 120,
    parameter bit VS_ACTIVE_LOW     = 1'b1,
    parameter int BLANK_SCALE_SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vga_vs,
    input  logic        mode_req,
    input  logic [1:0]  mode_idx,
    output logic        mode_ack,
    output logic        mode_err,
    output logic [1:0]  cur_mode,
    output logic        busy,
    output logic        gen_reset_n,
    output logic [11:0] h_total,
    output logic [11:0] h_sync,
    output logic [11:0] h_act_start,
    output logic [11:0] h_act_end,
    output logic [11:0] v_total,
    output logic [11:0] v_sync,
    output logic [11:0] v_act_start,
    output logic [11:0] v_act_end,
    output logic [1:0]  pclk_sel,
    input  logic        auto_en,
    input  logic        pat_load,
    input  logic [2:0]  pat_in,
    output logic [2:0]  pattern_sel
);

    logic        frame_start_s;
    state_t      state_r;
    state_t      state_next_s;
    logic        req_d_r;
    logic        req_rise_s;
    logic        err_set_s;
    logic        timeout_s;
    logic        blank_entry_s;
    logic [31:0] blank_len_s;
    logic [31:0] cnt_r;
    logic [1:0]  target_r;
    logic        same_r;
    logic        err_pend_r;
    timing_t     timing_r;
    logic [1:0]  cur_mode_r;
    logic        mode_ack_r;
    logic        mode_err_r;
    logic        busy_r;
    logic        gen_reset_n_r;
    logic [2:0]  pattern_r;
    logic        pat_pend_r;
    logic [2:0]  pat_val_r;
    logic [31:0] frame_cnt_r;

    vpg_frame_detect #(
        .VS_ACTIVE_LOW (VS_ACTIVE_LOW)
    ) u_frame_detect (
        .clk         (clk),
        .reset_n     (reset_n),
        .vga_vs      (vga_vs),
        .frame_start (frame_start_s)
    );

    assign req_rise_s    = mode_req & ~req_d_r;
    assign timeout_s     = (cnt_r >= 32'(FRAME_TIMEOUT - 1));
    // vsync is frozen while the generator is held in reset, so blanking is timed in cycles.
    assign blank_len_s   = (32'(BLANK_FRAMES) * 32'(timing_r.h_total) * 32'(timing_r.v_total))
                           >> BLANK_SCALE_SHIFT;
    assign blank_entry_s = (state_r != ST_BLANK) && (state_next_s == ST_BLANK);

    // Next-state decode for the mode-change handshake.
    always_comb begin
        state_next_s = state_r;
        err_set_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_rise_s) begin
                    if (32'(mode_idx) >= 32'(NUM_MODES)) begin
                        state_next_s = ST_ACK;
                        err_set_s    = 1'b1;
                    end else begin
                        state_next_s = ST_WAIT_FS;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_FS: begin
                if (frame_start_s) begin
                    state_next_s = same_r ? ST_ACK : ST_BLANK;
                end else if (timeout_s) begin
                    state_next_s = same_r ? ST_ACK : ST_BLANK;
                    err_set_s    = 1'b1;
                end else begin
                    state_next_s = ST_WAIT_FS;
                end
            end
            ST_BLANK: begin
                if ((cnt_r + 32'd1) >= blank_len_s) begin
                    state_next_s = ST_SETTLE;
                end else begin
                    state_next_s = ST_BLANK;
                end
            end
            ST_SETTLE: begin
                if (frame_start_s) begin
                    state_next_s = ST_ACK;
                end else if (timeout_s) begin
                    state_next_s = ST_ACK;
                    err_set_s    = 1'b1;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_ACK: begin
                if (!mode_req) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, shared timeout/blank counter, request capture and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            req_d_r       <= 1'b0;
            cnt_r         <= 32'd0;
            target_r      <= 2'd0;
            same_r        <= 1'b0;
            err_pend_r    <= 1'b0;
            mode_ack_r    <= 1'b0;
            mode_err_r    <= 1'b0;
            busy_r        <= 1'b0;
            gen_reset_n_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            req_d_r       <= mode_req;
            cnt_r         <= ((state_next_s != state_r) || (state_r == ST_IDLE)) ? 32'd0
                                                                                 : cnt_r + 32'd1;
            if ((state_r == ST_IDLE) && req_rise_s) begin
                target_r <= mode_idx;
                same_r   <= (mode_idx == cur_mode_r);
            end else begin
                target_r <= target_r;
                same_r   <= same_r;
            end
            if (state_next_s == ST_IDLE) begin
                err_pend_r <= 1'b0;
            end else begin
                err_pend_r <= err_pend_r | err_set_s;
            end
            mode_ack_r    <= (state_next_s == ST_ACK);
            mode_err_r    <= (state_next_s == ST_ACK) & (err_pend_r | err_set_s);
            busy_r        <= (state_next_s != ST_IDLE);
            gen_reset_n_r <= (state_next_s != ST_BLANK);
        end
    end

    // Timing row, pixel clock and current mode switch together, only while the generator is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timing_r   <= MODE_TABLE[0];
            cur_mode_r <= 2'd0;
        end else if (blank_entry_s) begin
            timing_r   <= MODE_TABLE[target_r];
            cur_mode_r <= target_r;
        end else begin
            timing_r   <= timing_r;
            cur_mode_r <= cur_mode_r;
        end
    end

    // Pattern selection: pending load beats auto-advance; everything frozen during a mode change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_r   <= 3'd0;
            pat_pend_r  <= 1'b0;
            pat_val_r   <= 3'd0;
            frame_cnt_r <= 32'd0;
        end else begin
            if (frame_start_s && !busy_r) begin
                if (pat_pend_r) begin
                    pattern_r   <= pat_val_r;
                    frame_cnt_r <= 32'd0;
                    pat_pend_r  <= 1'b0;
                end else if (!auto_en) begin
                    frame_cnt_r <= 32'd0;
                end else if (frame_cnt_r >= 32'(AUTO_FRAMES - 1)) begin
                    pattern_r   <= pat_step(pattern_r, NUM_PATTERNS);
                    frame_cnt_r <= 32'd0;
                end else begin
                    frame_cnt_r <= frame_cnt_r + 32'd1;
                end
            end else if (!auto_en && !busy_r) begin
                frame_cnt_r <= 32'd0;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
            if (pat_load) begin
                pat_pend_r <= 1'b1;
                pat_val_r  <= pat_reduce(pat_in, NUM_PATTERNS);
            end else begin
                pat_val_r  <= pat_val_r;
            end
        end
    end

    assign mode_ack    = mode_ack_r;
    assign mode_err    = mode_err_r;
    assign cur_mode    = cur_mode_r;
    assign busy        = busy_r;
    assign gen_reset_n = gen_reset_n_r;
    assign h_total     = timing_r.h_total;
    assign h_sync      = timing_r.h_sync;
    assign h_act_start = timing_r.h_act_start;
    assign h_act_end   = timing_r.h_act_end;
    assign v_total     = timing_r.v_total;
    assign v_sync      = timing_r.v_sync;
    assign v_act_start = timing_r.v_act_start;
    assign v_act_end   = timing_r.v_act_end;
    assign pclk_sel    = timing_r.pclk;
    assign pattern_sel = pattern_r;

endmodule
